multi_seq_check: RTL and testbench
==================================

// Module: multi_seq_check
// PURPOSE
//  Receive-side checker for the 4-phase constant-multiplier stream (x1, x3, x7, x8 of one input byte).
//  - Uses the grant strobe to locate phase 0.
//  - Recovers the operand from phase 0 and verifies phases 1-3 against 3x, 7x and 8x of that operand.
//  - Per frame, reports the recovered byte, a pass/fail pulse and a saturating error count.
//  Sits directly downstream of the multiplier sequencer in the beginner datapath testbench chain.
// PARAMETERS
//  DW      8    operand width; stream width is DW+3
//  CNT_W   16   width of saturating error counter
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  grant_i    in   1      phase-0 marker; high in the cycle seq_i carries x1
//  seq_i      in   DW+3   multiplier stream sample, one phase per cycle
//  sync_o     out  1      1 = locked to frame boundaries
//  data_o     out  DW     recovered operand of last completed frame
//  vld_o      out  1      1-cycle pulse: frame complete, data_o valid
//  err_o      out  1      1-cycle pulse: frame failed (mismatch or resync)
//  err_cnt_o  out  CNT_W  saturating count of err_o pulses
// BEHAVIOUR
//  Reset (sampled on rising clk while rst=1)
//   - sync_o=0, data_o=0, vld_o=0, err_o=0, err_cnt_o=0, state=HUNT, base=0, bad=0.
//  States: HUNT, PH3, PH7, PH8, DONE
//   - HUNT: wait for grant_i. On grant_i=1:
//       base<=seq_i[DW-1:0]; bad<=(seq_i[DW+2:DW]!=0); ->PH3.
//   - PH3: compare seq_i with (base<<1)+base; mismatch sets bad; ->PH7.
//   - PH7: compare seq_i with (base<<3)-base; mismatch sets bad; ->PH8.
//   - PH8: compare seq_i with base<<3; final bad = bad | mismatch; ->DONE.
//   - DONE (1 cycle; this cycle is the next frame's phase 0):
//       vld_o=1, data_o=base, err_o=final bad, sync_o=1;
//       grant_i=1 -> capture new base as in HUNT, ->PH3;
//       grant_i=0 -> sync_o<=0, ->HUNT.
//  Arithmetic
//   - All compare values are computed at DW+3 bits, unsigned; no overflow is possible (8*(2^DW-1) < 2^(DW+3)).
//  Latency
//   - grant_i at cycle T -> vld_o/err_o high during cycle T+3 (registered at the T+3 edge, i.e. visible after PH8 sample).
//   - Back-to-back frames produce one vld_o every 4 cycles.
//  sync_o
//   - Goes 1 on the first completed frame.
//   - Drops to 0 on a missing grant in DONE or on a resync.
//  Resync: grant_i=1 while in PH3/PH7/PH8
//   - Abort the current frame: err_o pulse next cycle, vld_o=0, sync_o<=0.
//   - Capture the new base from this cycle's seq_i; ->PH3.
//  err_cnt_o
//   - Increments on each err_o pulse; holds at all-ones.
//  data_o
//   - Holds its value between vld_o pulses and updates on every completed frame, including failed ones.
//  Reset mid-frame
//   - rst wins over all other inputs; the partial frame is discarded with no vld_o/err_o pulse.
// TESTING
//  1. rst 2 cycles, grant at T with seq 255,765,1785,2040
//       -> vld_o=1 at T+3, data_o=8'hFF, err_o=0, sync_o=1.
//  2. 3 back-to-back frames d=0,1,128 (seq 0,0,0,0 / 1,3,7,8 / 128,384,896,1024)
//       -> 3 vld pulses 4 cycles apart, no err, err_cnt_o=0.
//  3. d=5 frame with phase2 value 34 instead of 35
//       -> vld_o=1, err_o=1, data_o=5, err_cnt_o=1.
//  4. grant re-asserted in PH7
//       -> err_o pulse next cycle, sync_o=0, new frame 9,27,63,72 completes clean.
//  5. grant absent after PH8 -> sync_o=0 and HUNT, no further vld until next grant;
//     grant with seq_i=11'h100 (upper bits set) -> err_o at frame end.
//  6. rst asserted during PH3 -> all outputs 0 next cycle, no pulses;
//     force CNT_W=2 and 5 bad frames -> err_cnt_o saturates at 3.

Source files
------------

// File: rtl/multi_seq_check.sv
// Receive-side checker for the x1/x3/x7/x8 multiplier stream.
// Locks on grant_i, recovers the operand and flags bad frames.
module multi_seq_check #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant_i,
  input  logic [DW+2:0]    seq_i,
  output logic             sync_o,
  output logic [DW-1:0]    data_o,
  output logic             vld_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [2:0] HUNT = 3'd0;
  localparam logic [2:0] PH3  = 3'd1;
  localparam logic [2:0] PH7  = 3'd2;
  localparam logic [2:0] PH8  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]    state;
  logic [DW-1:0] base;
  logic          bad;

  logic [DW+2:0] b_ext;
  logic [DW+2:0] exp_v;
  logic          in_frame;
  logic          fin_bad;
  logic          fire_err;

  // Expected sample for the current phase and the error decision
  always_comb begin
    b_ext    = {3'b000, base};
    exp_v    = '0;
    in_frame = 1'b0;
    case (state)
      PH3: begin
        exp_v    = (b_ext << 1) + b_ext;
        in_frame = 1'b1;
      end
      PH7: begin
        exp_v    = (b_ext << 3) - b_ext;
        in_frame = 1'b1;
      end
      PH8: begin
        exp_v    = b_ext << 3;
        in_frame = 1'b1;
      end
      default: exp_v = '0;
    endcase
    fin_bad  = bad | (seq_i != exp_v);
    fire_err = (in_frame & grant_i)
             | ((state == PH8) & ~grant_i & fin_bad);
  end

  // Frame tracking, result registers and saturating error count
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      base      <= '0;
      bad       <= 1'b0;
      sync_o    <= 1'b0;
      data_o    <= '0;
      vld_o     <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      vld_o <= 1'b0;
      err_o <= 1'b0;
      if (fire_err && err_cnt_o != '1)
        err_cnt_o <= err_cnt_o + 1'b1;

      if (grant_i) begin
        base  <= seq_i[DW-1:0];
        bad   <= |seq_i[DW+2:DW];
        state <= PH3;
        if (in_frame) begin
          err_o  <= 1'b1;
          sync_o <= 1'b0;
        end
      end else begin
        case (state)
          HUNT, DONE: begin
            sync_o <= 1'b0;
            state  <= HUNT;
          end
          PH3: begin
            bad   <= fin_bad;
            state <= PH7;
          end
          PH7: begin
            bad   <= fin_bad;
            state <= PH8;
          end
          PH8: begin
            vld_o  <= 1'b1;
            err_o  <= fin_bad;
            data_o <= base;
            sync_o <= 1'b1;
            state  <= DONE;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_seq_check.sv
// Scoreboard bench for multi_seq_check.
// Frame-level model, randomized plus directed traffic.
module tb_multi_seq_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        grant;
  logic [10:0] seq;

  logic        sync_a, vld_a, err_a;
  logic [7:0]  data_a;
  logic [15:0] cnt_a;
  logic        sync_b, vld_b, err_b;
  logic [7:0]  data_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  multi_seq_check #(.DW(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .grant_i(grant), .seq_i(seq),
    .sync_o(sync_a), .data_o(data_a), .vld_o(vld_a),
    .err_o(err_a), .err_cnt_o(cnt_a)
  );

  multi_seq_check #(.DW(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .grant_i(grant), .seq_i(seq),
    .sync_o(sync_b), .data_o(data_b), .vld_o(vld_b),
    .err_o(err_b), .err_cnt_o(cnt_b)
  );

  typedef struct packed {
    logic       vld;
    logic       err;
    logic [7:0] data;
  } ev_t;

  ev_t         sb[$];
  logic [10:0] fq[$];
  int          raw_cnt = 0;
  logic        m_sync = 1'b0;
  logic [7:0]  m_data = 8'd0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Frame-level reference: collect 4 samples after grant, judge the frame
  task automatic model(input logic g, input logic [10:0] s, input logic r);
    int  d;
    bit  bd;
    if (r) begin
      fq.delete();
      raw_cnt = 0;
      m_sync  = 1'b0;
      m_data  = 8'd0;
    end else if (g) begin
      if (fq.size() != 0) begin
        sb.push_back('{vld: 1'b0, err: 1'b1, data: m_data});
        raw_cnt++;
        m_sync = 1'b0;
      end
      fq.delete();
      fq.push_back(s);
    end else if (fq.size() != 0) begin
      fq.push_back(s);
      if (fq.size() == 4) begin
        d  = int'(fq[0][7:0]);
        bd = (fq[0][10:8] != 3'd0) || (int'(fq[1]) != 3 * d)
          || (int'(fq[2]) != 7 * d) || (int'(fq[3]) != 8 * d);
        m_data = fq[0][7:0];
        m_sync = 1'b1;
        sb.push_back('{vld: 1'b1, err: bd, data: fq[0][7:0]});
        if (bd) raw_cnt++;
        fq.delete();
      end
    end else begin
      m_sync = 1'b0;
    end
  endtask

  task automatic cyc(input logic g, input logic [10:0] s,
                     input logic r = 1'b0);
    rst   = r;
    grant = g;
    seq   = s;
    model(g, s, r);
    @(negedge clk);
  endtask

  task automatic frame(input int d, input int ph = -1,
                       input int flip = 0);
    logic [10:0] v[4];
    v[0] = 11'(d);
    v[1] = 11'(3 * d);
    v[2] = 11'(7 * d);
    v[3] = 11'(8 * d);
    if (ph >= 0) v[ph] = v[ph] ^ 11'(flip);
    for (int i = 0; i < 4; i++) cyc(i == 0, v[i]);
  endtask

  // Monitor: pop expected events when the DUT pulses, check state each cycle
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (vld_a || err_a) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, vld_a, err_a}, 0);
        end else begin
          e = sb.pop_front();
          chk("vld", int'(vld_a), int'(e.vld));
          chk("err", int'(err_a), int'(e.err));
          if (e.vld) chk("frame_data", int'(data_a), int'(e.data));
        end
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("missing_pulse", 0, {30'd0, e.vld, e.err});
      end
      chk("sync", int'(sync_a), int'(m_sync));
      chk("data_hold", int'(data_a), int'(m_data));
      chk("cnt16", int'(cnt_a), sat(raw_cnt, 65535));
      chk("cnt2", int'(cnt_b), sat(raw_cnt, 3));
    end
  end

  initial begin
    int mode;
    rst   = 1'b1;
    grant = 1'b0;
    seq   = '0;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0);
    frame(255);
    cyc(0, 0);
    cyc(0, 0);
    frame(0);
    frame(1);
    frame(128);
    cyc(0, 0);
    frame(5, 2, 1);
    cyc(0, 0);
    cyc(1, 11'd4);
    cyc(0, 11'd12);
    frame(9);
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 11'h100);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 11'd5);
    cyc(0, 11'd15, 1);
    cyc(0, 0);
    for (int i = 0; i < 5; i++) frame(i + 2, 1, 4);
    cyc(0, 0);
    chk("cnt2_saturated", int'(cnt_b), 3);
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 6);
      case (mode)
        0, 1: frame($urandom_range(0, 255));
        2: frame($urandom_range(0, 255), $urandom_range(0, 3),
                 $urandom_range(1, 2047));
        3: frame($urandom_range(0, 255), 0,
                 $urandom_range(1, 7) << 8);
        4: for (int k = $urandom_range(0, 3); k > 0; k--)
             cyc(0, 11'($urandom_range(0, 2047)));
        5: begin
          int d = $urandom_range(0, 255);
          int n = $urandom_range(1, 3);
          cyc(1, 11'(d));
          if (n > 1) cyc(0, 11'(3 * d));
          if (n > 2) cyc(0, 11'(7 * d));
        end
        default: if ($urandom_range(0, 9) == 0) cyc(0, 0, 1);
      endcase
    end
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
